// File: rtl/sad_pipe_pkg.sv
// ============================================================================
// Module   : sad_pipe_pkg
// Purpose  : Shared constants and stage-entry type for the SAD pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sad_pipe_pkg;

    localparam int SAD_NUM_CH = 4;
    localparam int SAD_VAL_W  = 14;
    localparam int SAD_IDX_W  = 16;

    // Default-width entry; the top level re-declares it with its own widths.
    typedef struct packed {
        logic                           valid;
        logic [SAD_NUM_CH*SAD_VAL_W-1:0] value;
        logic [SAD_NUM_CH*SAD_IDX_W-1:0] index;
        logic                           trig;
    } sad_entry_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sad_pipe_reg_if.sv
// ============================================================================
// Module   : sad_pipe_reg_if
// Purpose  : Upstream/downstream handshake bundle; best_* and min_clear exist
//            only when SAD_PIPE_MIN_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sad_pipe_reg_if
    import sad_pipe_pkg::*;
#(
    parameter int NUM_CH = SAD_NUM_CH,
    parameter int VAL_W  = SAD_VAL_W,
    parameter int IDX_W  = SAD_IDX_W
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*VAL_W-1:0] in_value;
    logic [NUM_CH*IDX_W-1:0] in_index;
    logic [NUM_CH-1:0]       in_trigger;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_CH*VAL_W-1:0] out_value;
    logic [NUM_CH*IDX_W-1:0] out_index;
    logic                    out_trigger;

`ifdef SAD_PIPE_MIN_EN
    localparam int CH_W = ch_width(NUM_CH);
    logic             min_clear;
    logic             best_valid;
    logic [VAL_W-1:0] best_value;
    logic [IDX_W-1:0] best_index;
    logic [CH_W-1:0]  best_ch;

    modport master (
        output flush, in_valid, in_value, in_index, in_trigger, out_ready, min_clear,
        input  in_ready, out_valid, out_value, out_index, out_trigger,
               best_valid, best_value, best_index, best_ch
    );
    modport slave (
        input  flush, in_valid, in_value, in_index, in_trigger, out_ready, min_clear,
        output in_ready, out_valid, out_value, out_index, out_trigger,
               best_valid, best_value, best_index, best_ch
    );
`else
    modport master (
        output flush, in_valid, in_value, in_index, in_trigger, out_ready,
        input  in_ready, out_valid, out_value, out_index, out_trigger
    );
    modport slave (
        input  flush, in_valid, in_value, in_index, in_trigger, out_ready,
        output in_ready, out_valid, out_value, out_index, out_trigger
    );
`endif

endinterface

`default_nettype wire

// File: rtl/sad_pipe_stage.sv
// ============================================================================
// Module   : sad_pipe_stage
// Purpose  : One elastic register slice; data holds unless a valid word loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sad_pipe_stage
    import sad_pipe_pkg::*;
#(
    parameter type entry_t = sad_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   load,
    input  entry_t d,
    output entry_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (load) begin
            if (d.valid) begin
                q <= d;
            end else begin
                q.valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sad_pipe_reg.sv
// ============================================================================
// Module   : sad_pipe_reg
// Purpose  : DEPTH-stage elastic SAD register with bubble collapse and flush;
//            running-minimum tracker compiled in with SAD_PIPE_MIN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sad_pipe_reg
    import sad_pipe_pkg::*;
#(
    parameter int NUM_CH  = SAD_NUM_CH,
    parameter int VAL_W   = SAD_VAL_W,
    parameter int IDX_W   = SAD_IDX_W,
    parameter int DEPTH   = 1,
    parameter int TRIG_CH = NUM_CH - 1
) (
    input  logic          clk,
    input  logic          rst,
    sad_pipe_reg_if.slave bus
);

    localparam int LAST = DEPTH - 1;

    typedef struct packed {
        logic                    valid;
        logic [NUM_CH*VAL_W-1:0] value;
        logic [NUM_CH*IDX_W-1:0] index;
        logic                    trig;
    } entry_t;

    entry_t           head;
    entry_t           src [DEPTH];
    entry_t           stq [DEPTH];
    logic [DEPTH-1:0] stage_v;
    logic [DEPTH-1:0] load;

    assign head = {bus.in_valid, bus.in_value, bus.in_index, bus.in_trigger[TRIG_CH]};

    // Stage k may load if out_ready or any stage from k downward has a hole.
    always_comb begin
        load = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic hole;
            hole = bus.out_ready;
            for (int j = k; j < DEPTH; j++) begin
                hole = hole | ~stage_v[j];
            end
            load[k] = hole;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src[k] = head;
        end else begin : g_body
            assign src[k] = stq[k-1];
        end

        sad_pipe_stage #(
            .entry_t (entry_t)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (bus.flush),
            .load  (load[k]),
            .d     (src[k]),
            .q     (stq[k])
        );

        assign stage_v[k] = stq[k].valid;
    end

    assign bus.in_ready    = load[0];
    assign bus.out_valid   = stq[LAST].valid;
    assign bus.out_value   = stq[LAST].value;
    assign bus.out_index   = stq[LAST].index;
    assign bus.out_trigger = stq[LAST].trig & stq[LAST].valid;

`ifdef SAD_PIPE_MIN_EN
    localparam int CH_W = ch_width(NUM_CH);

    logic [VAL_W-1:0] min_val;
    logic [IDX_W-1:0] min_idx;
    logic [CH_W-1:0]  min_ch;
    logic             trk_valid;
    logic [VAL_W-1:0] trk_value;
    logic [IDX_W-1:0] trk_index;
    logic [CH_W-1:0]  trk_ch;

    // Strict compare keeps the lowest channel on ties.
    always_comb begin
        min_val = bus.out_value[VAL_W-1:0];
        min_idx = bus.out_index[IDX_W-1:0];
        min_ch  = '0;
        for (int c = 1; c < NUM_CH; c++) begin
            if (bus.out_value[c*VAL_W +: VAL_W] < min_val) begin
                min_val = bus.out_value[c*VAL_W +: VAL_W];
                min_idx = bus.out_index[c*IDX_W +: IDX_W];
                min_ch  = CH_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush || bus.min_clear) begin
            trk_valid <= 1'b0;
            trk_value <= '1;
            trk_index <= '0;
            trk_ch    <= '0;
        end else if (bus.out_valid && bus.out_ready && (!trk_valid || (min_val < trk_value))) begin
            trk_valid <= 1'b1;
            trk_value <= min_val;
            trk_index <= min_idx;
            trk_ch    <= min_ch;
        end
    end

    assign bus.best_valid = trk_valid;
    assign bus.best_value = trk_value;
    assign bus.best_index = trk_index;
    assign bus.best_ch    = trk_ch;
`endif

endmodule

`default_nettype wire

// File: doc/sad_pipe_reg.md
# sad_pipe_reg

Parametrised, elastic inter-stage register for the SAD search datapath. It carries NUM_CH channels of (value, index) pairs plus a boss-trigger flag across DEPTH register stages, and adds three things: valid/ready flow control with bubble collapse, synchronous flush, and reset. It replaces the fixed per-stage SAD pipeline registers between any two SAD stages. Optionally, it tracks the running best (minimum) value seen at its output.

## Interface
Parameters:
- NUM_CH, 4: number of parallel channels (threads), 1..8.
- VAL_W, 14: SAD value width per channel.
- IDX_W, 16: index width per channel.
- DEPTH, 1: number of register stages, 1..4.
- TRIG_CH, NUM_CH-1: input channel whose trigger bit is forwarded.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  upstream word present.
- in_ready  out  1  this block accepts the upstream word this cycle.
- in_value  in  NUM_CH*VAL_W  channel c at [c*VAL_W +: VAL_W].
- in_index  in  NUM_CH*IDX_W  channel c at [c*IDX_W +: IDX_W].
- in_trigger  in  NUM_CH  per-channel boss trigger.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts the output word.
- out_value  out  NUM_CH*VAL_W  same packing as in_value.
- out_index  out  NUM_CH*IDX_W  same packing as in_index.
- out_trigger  out  1  forwarded in_trigger[TRIG_CH].
- best_valid, best_value[VAL_W], best_index[IDX_W], best_ch[$clog2(NUM_CH) or 1]  out  present only with SAD_PIPE_MIN_EN.
- min_clear  in  1  present only with SAD_PIPE_MIN_EN.

## Operation
- Each stage k holds: v[k], value, index, trig.
- Stage 0 is loaded from the inputs. Stage k>0 is loaded from stage k-1. The outputs are driven from stage DEPTH-1.
- Advance rule: stage k loads when !v[k] or stage k+1 loads. For the last stage, the condition is !v[last] or out_ready. Consequently, bubbles collapse.
- in_ready equals the stage-0 load condition. This ready chain is combinational.
- A transfer occurs when valid and ready are both 1 on the same edge. A loading stage takes v from its source. Its data registers load only when the source valid is 1; otherwise they hold.
- flush clears every v[k] on the next edge. The input word offered in the flush cycle is discarded. Data registers hold their values.
- rst clears every v[k], all data registers, and the min tracker. rst has priority over flush, and flush has priority over load.
- out_trigger is the trig field of the last stage. It is qualified by out_valid: it is 0 whenever out_valid is 0.
- Arithmetic: no arithmetic on data. Widths pass straight through.

## Timing
- Reset values: out_valid=0, out_value=0, out_index=0, out_trigger=0, in_ready=1 (the cycle after reset), best_valid=0, best_value=all-ones, best_index=0, best_ch=0.
- Latency: DEPTH cycles from input transfer to out_valid, with no backpressure.
- Throughput: one word per cycle with out_ready held at 1.
- Full pipeline with out_ready=0: in_ready=0 and all stages hold. When out_ready rises, the whole pipeline advances in that same cycle.
- Empty pipeline: out_valid=0 and outputs hold their last data.
- rst or flush asserted mid-stream: the next cycle shows out_valid=0. Data resumes DEPTH cycles after the next accepted word.

## Configuration
- SAD_PIPE_MIN_EN defined: the min tracker is compiled in.
  - On each output transfer, it finds the minimum out_value across channels. Ties go to the lowest channel.
  - If best_valid=0, or the minimum is strictly less than best_value, it stores value, index and channel and sets best_valid. The update is visible one cycle after the transfer.
  - rst, flush or min_clear resets the tracker to its reset values. A clear has priority over a same-cycle update.
- SAD_PIPE_MIN_EN undefined: the best_* and min_clear ports and all tracker logic are absent. Pipeline behaviour is identical in both builds.

## Structure
- Package sad_pipe_pkg holds:
  - the default constants: SAD_NUM_CH=4, SAD_VAL_W=14, SAD_IDX_W=16;
  - the per-stage entry typedef (valid, value, index, trig).
- Sub-module sad_pipe_stage is one elastic register slice: entry in/out, load, flush, rst. The top level instantiates it DEPTH times with a generate loop. The min tracker stays in the top level.

## Test plan
- Single transfer at DEPTH=2:
  - Stimulus: in_value channel 0..3 = 100, 200, 300, 400; index = 1..4; in_trigger=4'b1000.
  - Required response: out_valid=1 exactly 2 cycles later with the same data and out_trigger=1.
- Backpressure with out_ready=0: stream 5 words at DEPTH=2. Required response: in_ready drops after 2 accepted words. Releasing out_ready delivers all 5 in order with no loss or duplication.
- Bubble collapse: send word A, idle one cycle, send word B, with out_ready=0. Required response: both A and B are resident, and in_ready=0.
- Flush in the same cycle as an input transfer: the pipeline holds 2 words. Required response: next cycle out_valid=0, and neither the held words nor the flush-cycle word appear.
- rst asserted while the pipeline is full: next cycle all outputs are at their reset values and in_ready=1.
- Min tracker (SAD_PIPE_MIN_EN), with min_clear mid-sequence:
  - Stimulus: outputs (50, 20, 20, 90) then (30, 10, 60, 70).
  - Required response: best = 20/channel 1, then 10/channel 1. After min_clear, best_valid=0.
